mem_port_arbiter: RTL

Two-requester arbiter that shares one single-port synchronous RAM between the tiny CPU's instruction-fetch path and its load/store (LW/SW) path. It sits between the CPU core and the unified program/data memory, sequences each access through a fixed issue/wait/respond cycle, and alternates grants round-robin so neither path can starve the other. The CPU stalls on each port until that port's ack pulse arrives.

---
 rtl/tiny_cpu_pkg.sv | 17 +
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU memory subsystem.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last. Zero latency, no state.
module rr_pick2
  import tiny_cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_IF;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[PORT_D]) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between fetch and load/store ports; each access
// takes MEM_LAT+3 cycles (idle, issue, MEM_LAT wait, respond); requesters stall until their ack.
module mem_port_arbiter
  import tiny_cpu_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  arb_state_t    state, state_nxt;
  logic [1:0]    wait_cnt, wait_cnt_nxt;

  logic          grant_q;
  logic          last_grant;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          pick_id;
  logic          pick_vld;
  logic          take_grant;
  logic          capture;
  logic          resp;

  rr_pick2 u_pick (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .grant      (pick_id),
    .valid      (pick_vld)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    take_grant   = 1'b0;
    capture      = 1'b0;
    resp         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          take_grant = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = LAT_M1;
      end
      ST_WAIT: begin
        // Last wait cycle is the one where the RAM's read data is valid.
        if (wait_cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - 2'd1;
        end
      end
      ST_RESP: begin
        resp      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_q    <= PORT_IF;
      last_grant <= PORT_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (take_grant) begin
        grant_q <= pick_id;
        addr_q  <= (pick_id == PORT_D) ? d_addr : if_addr;
        we_q    <= (pick_id == PORT_D) && d_we;
        // Fetches leave the write-data register untouched.
        if (pick_id == PORT_D) begin
          wdata_q <= d_wdata;
        end
      end
      if (capture && !we_q) begin
        if (grant_q == PORT_D) begin
          d_rdata_q <= mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
      if (resp) begin
        last_grant <= grant_q;
      end
    end
  end

  assign mem_en    = (state == ST_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = resp && (grant_q == PORT_IF);
  assign d_ack     = resp && (grant_q == PORT_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != ST_IDLE);

endmodule
